// File: rtl/reg_ctrl_pkg.sv
// Shared types and sizes for the register-file access controller.
package reg_ctrl_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned NUM_REGS   = 32;
   localparam int unsigned STARVE_W   = 4;

   typedef enum logic [0:0] {
      WB_PRIO = 1'b0,
      ID_PRIO = 1'b1
   } arb_state_t;

   // One-hot mask selecting a single register of the pending vector.
   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
      return NUM_REGS'(1) << addr;
   endfunction

endpackage

// File: rtl/reg_access_ctrl_if.sv
// ID/WB request bundle plus register-file control outputs of reg_access_ctrl.
interface reg_access_ctrl_if
   import reg_ctrl_pkg::*;
#(
   parameter int unsigned BITSIZE = 32
) ();

   logic                  ID_REG_req_i;
   logic [REG_ADDR_W-1:0] ID_REG_rs1_i;
   logic [REG_ADDR_W-1:0] ID_REG_rs2_i;
   logic [REG_ADDR_W-1:0] ID_REG_rd_i;
   logic                  ID_REG_issue_i;
   logic                  REG_ID_access_o;

   logic                  WB_REG_req_i;
   logic [REG_ADDR_W-1:0] WB_REG_rd_i;
   logic [BITSIZE-1:0]    WB_REG_data_i;
   logic                  REG_WB_ack_o;

   logic [REG_ADDR_W-1:0] CTRL_RF_raddr1_o;
   logic [REG_ADDR_W-1:0] CTRL_RF_raddr2_o;
   logic                  CTRL_RF_we_o;
   logic [REG_ADDR_W-1:0] CTRL_RF_waddr_o;
   logic [BITSIZE-1:0]    CTRL_RF_wdata_o;
   logic [NUM_REGS-1:0]   CTRL_sb_o;

   modport slave (
      input  ID_REG_req_i, ID_REG_rs1_i, ID_REG_rs2_i, ID_REG_rd_i, ID_REG_issue_i,
      input  WB_REG_req_i, WB_REG_rd_i, WB_REG_data_i,
      output REG_ID_access_o, REG_WB_ack_o,
      output CTRL_RF_raddr1_o, CTRL_RF_raddr2_o, CTRL_RF_we_o,
      output CTRL_RF_waddr_o, CTRL_RF_wdata_o, CTRL_sb_o
   );

   modport master (
      output ID_REG_req_i, ID_REG_rs1_i, ID_REG_rs2_i, ID_REG_rd_i, ID_REG_issue_i,
      output WB_REG_req_i, WB_REG_rd_i, WB_REG_data_i,
      input  REG_ID_access_o, REG_WB_ack_o,
      input  CTRL_RF_raddr1_o, CTRL_RF_raddr2_o, CTRL_RF_we_o,
      input  CTRL_RF_waddr_o, CTRL_RF_wdata_o, CTRL_sb_o
   );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write vector for in-flight destination registers; r0 is never pending.
module reg_scoreboard
   import reg_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  set_en,
   input  logic [REG_ADDR_W-1:0] set_addr,
   input  logic                  clr_en,
   input  logic [REG_ADDR_W-1:0] clr_addr,
   input  logic [REG_ADDR_W-1:0] look_a,
   input  logic [REG_ADDR_W-1:0] look_b,
   input  logic [REG_ADDR_W-1:0] look_c,
   output logic                  hit_a,
   output logic                  hit_b,
   output logic                  hit_c,
   output logic [NUM_REGS-1:0]   pending
);

   logic [NUM_REGS-1:0] sb_q;
   logic [NUM_REGS-1:0] sb_d;
   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] clr_mask;

   // Set is applied after clear so a same-cycle collision leaves the bit pending.
   always_comb begin
      set_mask = set_en ? reg_onehot(set_addr) : '0;
      clr_mask = clr_en ? reg_onehot(clr_addr) : '0;
      sb_d     = (sb_q & ~clr_mask) | set_mask;
      sb_d[0]  = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sb_q <= '0;
      else        sb_q <= sb_d;
   end

   assign hit_a   = sb_q[look_a];
   assign hit_b   = sb_q[look_b];
   assign hit_c   = sb_q[look_c];
   assign pending = sb_q;

endmodule

// File: rtl/reg_access_ctrl.sv
// Single-port register-file arbiter between ID reads and WB writes, with RAW/WAW
// hazard blocking and a starvation counter that eventually lets ID win over WB.
module reg_access_ctrl
   import reg_ctrl_pkg::*;
#(
   parameter int unsigned BITSIZE    = 32,
   parameter int unsigned MAX_STARVE = 4
) (
   input  logic               clk,
   input  logic               resetn_i,
   reg_access_ctrl_if.slave   bus
);

   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(MAX_STARVE);

   arb_state_t          state_q;
   arb_state_t          state_d;
   logic [STARVE_W-1:0] starve_q;
   logic [STARVE_W-1:0] starve_d;
   logic                id_grant_q;

   logic                hit_rs1;
   logic                hit_rs2;
   logic                hit_rd;
   logic                hazard;
   logic                id_elig;
   logic                id_grant;
   logic                wb_grant;
   logic                sb_set;
   logic                sb_clr;
   logic [NUM_REGS-1:0] sb_vec;
   logic [BITSIZE-1:0]  wb_data;

   // The ID stage hands an instruction to EX the cycle after its operand read grant.
   assign sb_set = bus.ID_REG_issue_i && id_grant_q && (bus.ID_REG_rd_i != '0);
   assign sb_clr = wb_grant && (bus.WB_REG_rd_i != '0);

   reg_scoreboard u_sb (
      .clk      (clk),
      .rst_n    (resetn_i),
      .set_en   (sb_set),
      .set_addr (bus.ID_REG_rd_i),
      .clr_en   (sb_clr),
      .clr_addr (bus.WB_REG_rd_i),
      .look_a   (bus.ID_REG_rs1_i),
      .look_b   (bus.ID_REG_rs2_i),
      .look_c   (bus.ID_REG_rd_i),
      .hit_a    (hit_rs1),
      .hit_b    (hit_rs2),
      .hit_c    (hit_rd),
      .pending  (sb_vec)
   );

   assign hazard  = hit_rs1 | hit_rs2 | hit_rd;
   assign id_elig = bus.ID_REG_req_i && !hazard;

   // State register: arbitration priority, starve count and last ID grant.
   always_ff @(posedge clk or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q    <= WB_PRIO;
         starve_q   <= '0;
         id_grant_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         starve_q   <= starve_d;
         id_grant_q <= id_grant;
      end
   end

   // Next state: count ID losses, hand priority to ID at the limit, return after its grant.
   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      if (id_grant)
         starve_d = '0;
      else if (id_elig && wb_grant && (starve_q != '1))
         starve_d = starve_q + STARVE_W'(1);

      if (id_grant && (state_q == ID_PRIO))
         state_d = WB_PRIO;
      else if (starve_d >= STARVE_LIM)
         state_d = ID_PRIO;
   end

   // Grants: at most one per cycle, both forced low while reset is asserted.
   always_comb begin
      id_grant = 1'b0;
      wb_grant = 1'b0;
      if (resetn_i) begin
         case (state_q)
            WB_PRIO: begin
               wb_grant = bus.WB_REG_req_i;
               id_grant = id_elig && !bus.WB_REG_req_i;
            end
            ID_PRIO: begin
               id_grant = id_elig;
               wb_grant = bus.WB_REG_req_i && !id_elig;
            end
            default: begin
               id_grant = 1'b0;
               wb_grant = 1'b0;
            end
         endcase
      end
   end

   assign wb_data = bus.WB_REG_data_i;

   assign bus.REG_ID_access_o  = id_grant;
   assign bus.REG_WB_ack_o     = wb_grant;
   assign bus.CTRL_RF_we_o     = sb_clr;
   assign bus.CTRL_RF_raddr1_o = bus.ID_REG_rs1_i;
   assign bus.CTRL_RF_raddr2_o = bus.ID_REG_rs2_i;
   assign bus.CTRL_RF_waddr_o  = bus.WB_REG_rd_i;
   assign bus.CTRL_RF_wdata_o  = wb_data;
   assign bus.CTRL_sb_o        = sb_vec;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed bench for reg_access_ctrl: expected outputs queued per step, checked before each rising edge.
module tb_reg_access_ctrl;
   import reg_ctrl_pkg::*;

   typedef struct packed {
      logic        access;
      logic        ack;
      logic        we;
      logic [31:0] sb;
      logic [4:0]  raddr1;
      logic [4:0]  raddr2;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } exp_t;

   logic clk = 1'b0;
   logic resetn;
   int   checks   = 0;
   int   failures = 0;
   int   step_no  = 0;
   exp_t exp_q[$];
   logic [31:0] sb_model;

   always #5 clk = ~clk;

   reg_access_ctrl_if #(.BITSIZE(32)) bus ();

   reg_access_ctrl #(.BITSIZE(32), .MAX_STARVE(4)) dut (
      .clk      (clk),
      .resetn_i (resetn),
      .bus      (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL s%0d_%s observed=%h expected=%h", step_no, tag, obs, expv);
      end
   endtask

   task automatic drive_id(input logic req, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic issue);
      bus.ID_REG_req_i   = req;
      bus.ID_REG_rs1_i   = rs1;
      bus.ID_REG_rs2_i   = rs2;
      bus.ID_REG_rd_i    = rd;
      bus.ID_REG_issue_i = issue;
   endtask

   task automatic drive_wb(input logic req, input logic [4:0] rd, input logic [31:0] data);
      bus.WB_REG_req_i  = req;
      bus.WB_REG_rd_i   = rd;
      bus.WB_REG_data_i = data;
   endtask

   task automatic push(input logic a, input logic k, input logic w, input logic [31:0] sb);
      exp_t e;
      e.access = a;
      e.ack    = k;
      e.we     = w;
      e.sb     = sb;
      e.raddr1 = bus.ID_REG_rs1_i;
      e.raddr2 = bus.ID_REG_rs2_i;
      e.waddr  = bus.WB_REG_rd_i;
      e.wdata  = bus.WB_REG_data_i;
      exp_q.push_back(e);
   endtask

   task automatic compare_out();
      exp_t e;
      step_no++;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL s%0d_queue observed=empty expected=entry", step_no);
         return;
      end
      e = exp_q.pop_front();
      chk("access", 32'(bus.REG_ID_access_o), 32'(e.access));
      chk("ack",    32'(bus.REG_WB_ack_o),    32'(e.ack));
      chk("we",     32'(bus.CTRL_RF_we_o),    32'(e.we));
      chk("sb",     bus.CTRL_sb_o,            e.sb);
      chk("raddr1", 32'(bus.CTRL_RF_raddr1_o), 32'(e.raddr1));
      chk("raddr2", 32'(bus.CTRL_RF_raddr2_o), 32'(e.raddr2));
      chk("waddr",  32'(bus.CTRL_RF_waddr_o),  32'(e.waddr));
      chk("wdata",  bus.CTRL_RF_wdata_o,       e.wdata);
   endtask

   // Inputs are driven just after a falling edge; outputs sampled 1 ns before the rising edge.
   task automatic step(input logic a, input logic k, input logic w, input logic [31:0] sb);
      push(a, k, w, sb);
      #4;
      compare_out();
      @(negedge clk);
   endtask

   initial begin
      // Reset: grants and scoreboard low even with requests present, addresses pass through.
      resetn = 1'b0;
      drive_id(1'b1, 5'd5, 5'd6, 5'd7, 1'b1);
      drive_wb(1'b1, 5'd7, 32'h0000_1234);
      push(1'b0, 1'b0, 1'b0, 32'h0);
      #2;
      compare_out();
      @(negedge clk);
      resetn = 1'b1;

      // Read grant with WB idle, then issue reserves rd=7.
      drive_id(1'b1, 5'd5, 5'd6, 5'd7, 1'b0); drive_wb(1'b0, 5'd0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      drive_id(1'b0, 5'd5, 5'd6, 5'd7, 1'b1);
      step(1'b0, 1'b0, 1'b0, 32'h0);

      // RAW on r7 blocks ID; WB write of r7 clears it, ID granted the next cycle.
      drive_id(1'b1, 5'd7, 5'd0, 5'd8, 1'b0); drive_wb(1'b1, 5'd7, 32'hDEAD_BEEF);
      step(1'b0, 1'b1, 1'b1, 32'h0000_0080);
      drive_wb(1'b0, 5'd0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0);

      // Issue with rd=0 reserves nothing; issue without a preceding grant is ignored.
      drive_id(1'b0, 5'd7, 5'd0, 5'd0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      drive_id(1'b0, 5'd0, 5'd0, 5'd12, 1'b0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      drive_id(1'b0, 5'd0, 5'd0, 5'd12, 1'b1);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 32'h0);

      // Starvation: four WB wins, ID on the fifth cycle, then WB wins again.
      drive_id(1'b1, 5'd1, 5'd2, 5'd9, 1'b0);
      for (int i = 0; i < 4; i++) begin
         drive_wb(1'b1, 5'd10, 32'h1000 + 32'(i));
         step(1'b0, 1'b1, 1'b1, 32'h0);
      end
      step(1'b1, 1'b0, 1'b0, 32'h0);
      drive_id(1'b0, 5'd1, 5'd2, 5'd9, 1'b1);
      step(1'b0, 1'b1, 1'b1, 32'h0);
      drive_id(1'b1, 5'd1, 5'd2, 5'd11, 1'b0);
      step(1'b0, 1'b1, 1'b1, 32'h0000_0200);
      drive_wb(1'b0, 5'd0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0000_0200);
      drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0); drive_wb(1'b1, 5'd9, 32'h0000_0009);
      step(1'b0, 1'b1, 1'b1, 32'h0000_0200);

      // Same-cycle reservation and write-back of r3: the reservation survives.
      drive_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b0); drive_wb(1'b0, 5'd0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      drive_id(1'b0, 5'd0, 5'd0, 5'd3, 1'b1); drive_wb(1'b1, 5'd3, 32'h0000_0333);
      step(1'b0, 1'b1, 1'b1, 32'h0);
      drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0); drive_wb(1'b0, 5'd0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0000_0008);
      drive_wb(1'b1, 5'd3, 32'h0000_0444);
      step(1'b0, 1'b1, 1'b1, 32'h0000_0008);

      // Write to r0 is acked without a register-file write.
      drive_wb(1'b1, 5'd0, 32'h0000_0555);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      drive_wb(1'b0, 5'd0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);

      // Build scoreboard 0xF0, then starve ID until it holds priority.
      sb_model = 32'h0;
      for (int r = 4; r < 8; r++) begin
         drive_id(1'b1, 5'd0, 5'd0, 5'(r), 1'b0);
         step(1'b1, 1'b0, 1'b0, sb_model);
         drive_id(1'b0, 5'd0, 5'd0, 5'(r), 1'b1);
         step(1'b0, 1'b0, 1'b0, sb_model);
         sb_model = sb_model | (32'h1 << r);
      end
      drive_id(1'b1, 5'd1, 5'd2, 5'd8, 1'b0);
      for (int i = 0; i < 4; i++) begin
         drive_wb(1'b1, 5'd9, 32'h2000 + 32'(i));
         step(1'b0, 1'b1, 1'b1, 32'h0000_00F0);
      end

      // Asynchronous reset mid-cycle: outputs drop at once, pending reservations lost.
      push(1'b0, 1'b0, 1'b0, 32'h0);
      #2;
      resetn = 1'b0;
      #1;
      compare_out();
      @(negedge clk);
      resetn = 1'b1;

      // After reset WB has priority again and the starve count restarts from zero.
      for (int i = 0; i < 4; i++) begin
         drive_wb(1'b1, 5'd9, 32'h3000 + 32'(i));
         step(1'b0, 1'b1, 1'b1, 32'h0);
      end
      step(1'b1, 1'b0, 1'b0, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
